// File: rtl/fpu_serial_if_v2_if.sv
// Pin-side, core-side and output-stream signals of the FP16 serial front/back-end.
interface fpu_serial_if_v2_if #(
    parameter int FP_W       = 16,
    parameter int IN_LANE    = 4,
    parameter int OUT_LANE   = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [2*IN_LANE-1:0] in_data;
    logic                 in_en;
    logic [1:0]           op;
    logic [FP_W-1:0]      core_a;
    logic [FP_W-1:0]      core_b;
    logic                 core_sel;
    logic                 core_start;
    logic [FP_W-1:0]      core_result;
    logic [OUT_LANE-1:0]  out_data;
    logic                 out_valid;
    logic                 out_first;
    logic                 out_ready;
    logic [CNT_W-1:0]     fifo_count;
    logic                 overflow;

    modport master (
        output in_data, in_en, op, core_result, out_ready,
        input  core_a, core_b, core_sel, core_start,
        input  out_data, out_valid, out_first, fifo_count, overflow
    );

    modport slave (
        input  in_data, in_en, op, core_result, out_ready,
        output core_a, core_b, core_sel, core_start,
        output out_data, out_valid, out_first, fifo_count, overflow
    );
endinterface

// File: rtl/fpu_serial_if_v2.sv
// Serial front/back-end for the FP16 add/mul core: lane deserialiser, issue
// register, fixed-latency result pipe, result FIFO and lane serialiser.
module fpu_serial_if_v2 #(
    parameter int FP_W       = 16,
    parameter int IN_LANE    = 4,
    parameter int OUT_LANE   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CORE_LAT   = 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    fpu_serial_if_v2_if.slave bus
);
    localparam int BEATS_IN  = FP_W / IN_LANE;
    localparam int BEATS_OUT = FP_W / OUT_LANE;
    localparam int IC_W      = (BEATS_IN > 1) ? $clog2(BEATS_IN) : 1;
    localparam int OC_W      = (BEATS_OUT > 1) ? $clog2(BEATS_OUT) : 1;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [IC_W-1:0] LAST_IN  = IC_W'(BEATS_IN - 1);
    localparam logic [OC_W-1:0] LAST_OUT = OC_W'(BEATS_OUT - 1);
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic {IN_IDLE, IN_COLLECT} in_state_e;
    typedef enum logic {OUT_IDLE, OUT_SEND}  out_state_e;

    in_state_e        in_state_q, in_state_d;
    logic [IC_W-1:0]  cnt_q, cnt_d, idx;
    logic [FP_W-1:0]  a_q, a_d, b_q, b_d;
    logic [1:0]       op_q, op_d, op_cur;
    logic [FP_W-1:0]  core_a_q, core_a_d, core_b_q, core_b_d;
    logic             core_sel_q, core_sel_d, start_q, start_d, pass_q, pass_d;
    logic             last_beat;

    logic [CORE_LAT-1:0] vld_q, pas_q;
    logic [FP_W-1:0]     pdat_q [CORE_LAT];

    logic [FP_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push, push_ok, pop, fifo_full, fifo_empty, accept, last_acc;
    logic [FP_W-1:0]  push_data;

    out_state_e       out_state_q, out_state_d;
    logic [OC_W-1:0]  lane_q, lane_d;
    logic [FP_W-1:0]  shift_q, shift_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Lane capture; the issue register is loaded in the same cycle as the final beat.
    always_comb begin
        in_state_d = in_state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        core_a_d   = core_a_q;
        core_b_d   = core_b_q;
        core_sel_d = core_sel_q;
        pass_d     = pass_q;
        start_d    = 1'b0;
        op_cur     = op_q;
        idx        = cnt_q;
        last_beat  = 1'b0;
        case (in_state_q)
            IN_IDLE: begin
                if (bus.in_en) begin
                    a_d        = '0;
                    b_d        = '0;
                    op_d       = bus.op;
                    op_cur     = bus.op;
                    idx        = '0;
                    cnt_d      = IC_W'(1);
                    in_state_d = IN_COLLECT;
                    last_beat  = (BEATS_IN == 1);
                end
            end
            default: begin
                if (bus.in_en) begin
                    cnt_d     = cnt_q + IC_W'(1);
                    last_beat = (cnt_q == LAST_IN);
                end else begin
                    cnt_d      = '0;
                    in_state_d = IN_IDLE;
                end
            end
        endcase
        if (bus.in_en) begin
            a_d[idx*IN_LANE +: IN_LANE] = bus.in_data[IN_LANE-1:0];
            b_d[idx*IN_LANE +: IN_LANE] = bus.in_data[2*IN_LANE-1:IN_LANE];
        end
        if (last_beat) begin
            in_state_d = IN_IDLE;
            cnt_d      = '0;
            start_d    = 1'b1;
            core_a_d   = a_d;
            core_b_d   = (op_cur == OP_SUB) ? {~b_d[FP_W-1], b_d[FP_W-2:0]} : b_d;
            core_sel_d = (op_cur == OP_ADD) || (op_cur == OP_SUB);
            pass_d     = (op_cur == OP_PASS);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            in_state_q <= IN_IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            core_a_q   <= '0;
            core_b_q   <= '0;
            core_sel_q <= 1'b0;
            start_q    <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            in_state_q <= in_state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            core_a_q   <= core_a_d;
            core_b_q   <= core_b_d;
            core_sel_q <= core_sel_d;
            start_q    <= start_d;
            pass_q     <= pass_d;
        end
    end

    // Operand A travels with the pass flag so a later issue cannot overwrite it.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            vld_q <= '0;
            pas_q <= '0;
            for (int i = 0; i < CORE_LAT; i++) pdat_q[i] <= '0;
        end else begin
            vld_q[0]  <= start_q;
            pas_q[0]  <= start_q & pass_q;
            pdat_q[0] <= core_a_q;
            for (int i = 1; i < CORE_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                pas_q[i]  <= pas_q[i-1];
                pdat_q[i] <= pdat_q[i-1];
            end
        end
    end

    always_comb begin
        push       = vld_q[CORE_LAT-1];
        push_data  = pas_q[CORE_LAT-1] ? pdat_q[CORE_LAT-1] : bus.core_result;
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        accept     = (out_state_q == OUT_SEND) && bus.out_ready;
        last_acc   = accept && (lane_q == LAST_OUT);
        pop        = !fifo_empty && ((out_state_q == OUT_IDLE) || last_acc);
        push_ok    = push && (!fifo_full || pop);
        overflow_d = overflow_q | (push & fifo_full & ~pop);
        count_d    = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // A pop on the last accepted lane reloads the shifter so words stream without a gap.
    always_comb begin
        out_state_d = out_state_q;
        lane_d      = lane_q;
        shift_d     = shift_q;
        if (pop) begin
            out_state_d = OUT_SEND;
            lane_d      = '0;
            shift_d     = mem_q[rptr_q];
        end else if (last_acc) begin
            out_state_d = OUT_IDLE;
            lane_d      = '0;
        end else if (accept) begin
            lane_d  = lane_q + OC_W'(1);
            shift_d = shift_q >> OUT_LANE;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push_ok) mem_q[wptr_q] <= push_data;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            out_state_q <= OUT_IDLE;
            lane_q      <= '0;
            shift_q     <= '0;
        end else begin
            if (push_ok) wptr_q <= ptr_inc(wptr_q);
            if (pop)     rptr_q <= ptr_inc(rptr_q);
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            out_state_q <= out_state_d;
            lane_q      <= lane_d;
            shift_q     <= shift_d;
        end
    end

    assign bus.core_a     = core_a_q;
    assign bus.core_b     = core_b_q;
    assign bus.core_sel   = core_sel_q;
    assign bus.core_start = start_q;
    assign bus.out_data   = shift_q[OUT_LANE-1:0];
    assign bus.out_valid  = (out_state_q == OUT_SEND);
    assign bus.out_first  = (out_state_q == OUT_SEND) && (lane_q == '0);
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;
endmodule
